axis_src_arbiter: RTL and testbench
===================================

Name: axis_src_arbiter

Overview:
- Shares one AXI-Stream master path (the backend feeding the FSIC axis master, or the AXIS bus directly) among NUM_SRC packet sources.
- Arbitration is round-robin at packet granularity. A grant is held until the beat carrying tlast has been accepted.
- The output is a registered valid/ready stage. m_tid carries the granted source index so the far end can demultiplex.

Parameters:
- NUM_SRC, 4, number of requesters (2..4).
- TID_W, 2, width of m_tid and arb_grant; NUM_SRC <= 2**TID_W.
- DATA_W, 32, tdata width; tstrb/tkeep width is DATA_W/8.
- USER_W, 2, tuser width.
- TIMEOUT_CYC, 16, starvation limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- s_tvalid  in  NUM_SRC  per-source valid
- s_tready  out  NUM_SRC  per-source ready
- s_tdata  in  NUM_SRC*DATA_W  flattened; source i occupies [i*DATA_W +: DATA_W]
- s_tstrb  in  NUM_SRC*DATA_W/8  flattened strobes
- s_tkeep  in  NUM_SRC*DATA_W/8  flattened keeps
- s_tuser  in  NUM_SRC*USER_W  flattened user
- s_tlast  in  NUM_SRC  per-source last
- m_tvalid  out  1  output valid
- m_tdata  out  DATA_W  output data
- m_tstrb  out  DATA_W/8  output strobe
- m_tkeep  out  DATA_W/8  output keep
- m_tuser  out  USER_W  output user
- m_tid  out  TID_W  index of the source that produced the beat
- m_tlast  out  1  output last
- m_tready  in  1  downstream ready
- arb_busy  out  1  high while in S_BUSY
- arb_grant  out  TID_W  current or most recent grant index
- arb_abort  out  1  one-cycle pulse on a timeout abort (tied 0 without the feature)

Behaviour:
- Reset values: all m_* = 0, s_tready = 0, arb_busy = 0, arb_grant = 0, arb_abort = 0. Round-robin pointer last_grant = NUM_SRC-1, so source 0 wins first. The FSM enters S_IDLE.
- Reset asserted mid-packet drops the packet without a tlast. Sources restart their packets after reset.
- FSM S_IDLE:
  - If any s_tvalid is set, register the grant as the first requester found searching from last_grant+1 upward, modulo NUM_SRC. Go to S_BUSY.
  - Arbitration latency is 1 cycle: s_tready of the granted source can rise at the earliest on the cycle after the request is seen.
- FSM S_BUSY:
  - load = !m_tvalid || m_tready.
  - s_tready[g] = load. Every other s_tready = 0.
  - On s_tvalid[g] && s_tready[g], register the beat into the m_* registers, with m_tid = g and m_tvalid = 1.
  - If load and no beat is accepted, m_tvalid is cleared.
  - If the accepted beat has s_tlast = 1: last_grant <= g, next state S_IDLE.
- Output register rules:
  - m_* hold stable while m_tvalid && !m_tready.
  - In S_IDLE, m_tvalid is cleared once m_tready is seen.
  - Throughput is 1 beat/cycle within a packet, with 1 bubble cycle between packets. The output register drains in parallel with arbitration, so beats are never lost.
- Single-beat packet (tlast on the first beat): granted, accepted, back to S_IDLE in 2 cycles total.
- Sources not requesting are skipped. With a single requester, it wins every packet.
- A source dropping s_tvalid mid-packet stalls the grant; the grant is not reassigned (except with the feature).
- arb_grant updates on every grant. It is held in S_IDLE and is not cleared.

Optional Feature:
- Macro: AXIS_ARB_TIMEOUT_EN.
- With it:
  - A starvation counter (8 bits, saturating) increments in S_BUSY on each cycle where load && !s_tvalid[g]. It clears on any accepted beat.
  - When the counter reaches TIMEOUT_CYC and load is high, the block injects a terminator beat: m_tdata = 0, m_tkeep = 0, m_tstrb = 0, m_tlast = 1, m_tid = g.
  - It pulses arb_abort for 1 cycle, sets last_grant <= g, and goes to S_IDLE.
- Without it: no counter, arb_abort is tied 0, and the grant is held indefinitely.

Decomposition:
- Package axis_arb_pkg holds:
  - the state enum {S_IDLE, S_BUSY};
  - localparams for the strobe width (DATA_W/8);
  - a function returning the round-robin winner given a request vector and the pointer.
- One sub-module, rr_pick: a combinational round-robin priority picker (req vector + last_grant -> grant index and found flag). It is reusable by the control-logic arbiter.

Test Plan:
- Src0 sends a 3-beat packet (0xA0..0xA2, tlast on 0xA2), m_tready = 1 -> m_tdata A0, A1, A2 on consecutive cycles, m_tid = 0, m_tlast only on A2, arb_busy low one cycle after.
- Src0, src1 and src2 all request continuously with 2-beat packets -> grant order 0, 1, 2, 0, 1; m_tid matches; exactly 1 bubble between packets.
- m_tready held low for 5 cycles mid-packet -> m_tdata and m_tid stable, s_tready[g] = 0, and no beat lost once m_tready rises.
- rst_n pulsed low during beat 2 of a src1 packet -> all outputs 0 immediately; after release, src0 wins first when src0 and src1 both request.
- AXIS_ARB_TIMEOUT_EN, TIMEOUT_CYC = 16, src2 stops valid after beat 1 -> after 16 idle cycles, a beat with tkeep = 0 and tlast = 1, arb_abort pulses once, then src3 (pending) is granted.
- Single-beat packets from src3 only -> each granted within 1 cycle of request, m_tlast = 1 on every beat, and m_tid = 3.

Source files
------------

// File: rtl/axis_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_arb_pkg
// Description : Shared types and helpers for the AXI-Stream source arbiter.
//               - arb_state_e : arbiter FSM states
//               - BYTE_W / strb_width() : tstrb/tkeep width derivation
//               - rr_winner() : round-robin winner search over a request vector
// Revision    : 1.0 - initial release
// ============================================================================
package axis_arb_pkg;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } arb_state_e;

  // Bits per strobe/keep lane; strobe width is DATA_W / BYTE_W.
  localparam int unsigned BYTE_W  = 8;
  // Widest request vector the round-robin helper handles.
  localparam int unsigned MAX_SRC = 16;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } rr_result_t;

  function automatic int unsigned strb_width(input int unsigned data_w);
    return data_w / BYTE_W;
  endfunction

  // First requester found searching upward from last+1, wrapping at num.
  function automatic rr_result_t rr_winner(input logic [MAX_SRC-1:0] req,
                                           input int unsigned        last,
                                           input int unsigned        num);
    rr_result_t  r;
    int unsigned idx;
    r   = '0;
    idx = 0;
    for (int unsigned k = 1; k <= MAX_SRC; k++) begin
      if (k <= num && !r.found) begin
        idx = (last + k) % num;
        if (req[idx[3:0]]) begin
          r.found = 1'b1;
          r.idx   = idx[3:0];
        end
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_src_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin priority picker.
//               Ports: req        - request vector (NUM_SRC)
//                      last_grant - index of the most recent winner
//                      grant      - winning index (valid when found)
//                      found      - at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
  import axis_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int TID_W   = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [TID_W-1:0]   last_grant,
  output logic [TID_W-1:0]   grant,
  output logic               found
);

  logic [MAX_SRC-1:0] req_ext;
  rr_result_t         pick;

  always_comb begin
    req_ext                = '0;
    req_ext[NUM_SRC-1:0]   = req;
    pick                   = rr_winner(req_ext, 32'(last_grant), NUM_SRC);
    grant                  = TID_W'(pick.idx);
    found                  = pick.found;
  end

endmodule
`default_nettype wire

// File: rtl/axis_src_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axis_src_arbiter
// Description : Packet-granular round-robin arbiter sharing one AXI-Stream
//               master among NUM_SRC sources, with a registered output stage.
//               Ports: clk, rst_n (async, active-low)
//                      s_t*      - flattened per-source slave streams
//                      m_t*      - registered master stream, m_tid = source
//                      arb_busy  - a packet grant is active
//                      arb_grant - current / most recent grant index
//                      arb_abort - one-cycle pulse on a starvation abort
//               Optional feature macro: AXIS_ARB_TIMEOUT_EN (starvation
//               timeout that terminates a stalled packet).
// Revision    : 1.0 - initial release
// ============================================================================
module axis_src_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int TID_W       = 2,
  parameter int DATA_W      = 32,
  parameter int USER_W      = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_SRC-1:0]                  s_tvalid,
  output logic [NUM_SRC-1:0]                  s_tready,
  input  logic [NUM_SRC*DATA_W-1:0]           s_tdata,
  input  logic [NUM_SRC*(DATA_W/BYTE_W)-1:0]  s_tstrb,
  input  logic [NUM_SRC*(DATA_W/BYTE_W)-1:0]  s_tkeep,
  input  logic [NUM_SRC*USER_W-1:0]           s_tuser,
  input  logic [NUM_SRC-1:0]                  s_tlast,
  output logic                                m_tvalid,
  output logic [DATA_W-1:0]                   m_tdata,
  output logic [DATA_W/BYTE_W-1:0]            m_tstrb,
  output logic [DATA_W/BYTE_W-1:0]            m_tkeep,
  output logic [USER_W-1:0]                   m_tuser,
  output logic [TID_W-1:0]                    m_tid,
  output logic                                m_tlast,
  input  logic                                m_tready,
  output logic                                arb_busy,
  output logic [TID_W-1:0]                    arb_grant,
  output logic                                arb_abort
);

  localparam int STRB_W = int'(strb_width(DATA_W));

  if (NUM_SRC < 2 || NUM_SRC > 4 || NUM_SRC > (1 << TID_W) ||
      TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_cfg
    $error("axis_src_arbiter: unsupported parameter combination");
  end

  arb_state_e          state_q, state_d;
  logic [TID_W-1:0]    grant_q, grant_d;
  logic [TID_W-1:0]    last_grant_q, last_grant_d;
  logic                m_tvalid_q, m_tvalid_d;
  logic [DATA_W-1:0]   m_tdata_q, m_tdata_d;
  logic [STRB_W-1:0]   m_tstrb_q, m_tstrb_d;
  logic [STRB_W-1:0]   m_tkeep_q, m_tkeep_d;
  logic [USER_W-1:0]   m_tuser_q, m_tuser_d;
  logic [TID_W-1:0]    m_tid_q, m_tid_d;
  logic                m_tlast_q, m_tlast_d;
  logic                arb_abort_q, arb_abort_d;

  logic [TID_W-1:0]    pick_idx;
  logic                pick_found;
  logic                load, accept, timeout_hit;
  logic                sel_valid, sel_last;
  logic [DATA_W-1:0]   sel_data;
  logic [STRB_W-1:0]   sel_strb, sel_keep;
  logic [USER_W-1:0]   sel_user;

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .TID_W   (TID_W)
  ) u_rr_pick (
    .req        (s_tvalid),
    .last_grant (last_grant_q),
    .grant      (pick_idx),
    .found      (pick_found)
  );

  // Mux the granted source onto a single beat.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_strb  = '0;
    sel_keep  = '0;
    sel_user  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q == TID_W'(i)) begin
        sel_valid = s_tvalid[i];
        sel_last  = s_tlast[i];
        sel_data  = s_tdata[i*DATA_W +: DATA_W];
        sel_strb  = s_tstrb[i*STRB_W +: STRB_W];
        sel_keep  = s_tkeep[i*STRB_W +: STRB_W];
        sel_user  = s_tuser[i*USER_W +: USER_W];
      end
    end
  end

  // Output register can take a new beat when empty or being drained.
  assign load   = !m_tvalid_q || m_tready;
  assign accept = (state_q == S_BUSY) && load && !timeout_hit && sel_valid;

`ifdef AXIS_ARB_TIMEOUT_EN
  logic [7:0] starve_q, starve_d;

  assign timeout_hit = (state_q == S_BUSY) && load && (starve_q == 8'(TIMEOUT_CYC));

  // Counts cycles the output could take a beat but the granted source has none.
  always_comb begin
    starve_d = starve_q;
    if (state_q != S_BUSY || accept || timeout_hit) begin
      starve_d = '0;
    end else if (load && !sel_valid && starve_q != 8'hFF) begin
      starve_d = starve_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_q <= '0;
    else        starve_q <= starve_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // The terminator beat occupies the output slot, so the source is held off.
  always_comb begin
    s_tready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      s_tready[i] = (state_q == S_BUSY) && load && !timeout_hit &&
                    (grant_q == TID_W'(i));
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    m_tvalid_d   = m_tvalid_q;
    m_tdata_d    = m_tdata_q;
    m_tstrb_d    = m_tstrb_q;
    m_tkeep_d    = m_tkeep_q;
    m_tuser_d    = m_tuser_q;
    m_tid_d      = m_tid_q;
    m_tlast_d    = m_tlast_q;
    arb_abort_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Drain the last beat of the previous packet while arbitrating.
        if (m_tready) m_tvalid_d = 1'b0;
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (timeout_hit) begin
          m_tvalid_d   = 1'b1;
          m_tdata_d    = '0;
          m_tstrb_d    = '0;
          m_tkeep_d    = '0;
          m_tuser_d    = '0;
          m_tid_d      = grant_q;
          m_tlast_d    = 1'b1;
          arb_abort_d  = 1'b1;
          last_grant_d = grant_q;
          state_d      = S_IDLE;
        end else if (accept) begin
          m_tvalid_d = 1'b1;
          m_tdata_d  = sel_data;
          m_tstrb_d  = sel_strb;
          m_tkeep_d  = sel_keep;
          m_tuser_d  = sel_user;
          m_tid_d    = grant_q;
          m_tlast_d  = sel_last;
          if (sel_last) begin
            last_grant_d = grant_q;
            state_d      = S_IDLE;
          end
        end else if (load) begin
          m_tvalid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= TID_W'(NUM_SRC - 1);
      m_tvalid_q   <= 1'b0;
      m_tdata_q    <= '0;
      m_tstrb_q    <= '0;
      m_tkeep_q    <= '0;
      m_tuser_q    <= '0;
      m_tid_q      <= '0;
      m_tlast_q    <= 1'b0;
      arb_abort_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      m_tvalid_q   <= m_tvalid_d;
      m_tdata_q    <= m_tdata_d;
      m_tstrb_q    <= m_tstrb_d;
      m_tkeep_q    <= m_tkeep_d;
      m_tuser_q    <= m_tuser_d;
      m_tid_q      <= m_tid_d;
      m_tlast_q    <= m_tlast_d;
      arb_abort_q  <= arb_abort_d;
    end
  end

  assign m_tvalid  = m_tvalid_q;
  assign m_tdata   = m_tdata_q;
  assign m_tstrb   = m_tstrb_q;
  assign m_tkeep   = m_tkeep_q;
  assign m_tuser   = m_tuser_q;
  assign m_tid     = m_tid_q;
  assign m_tlast   = m_tlast_q;
  assign arb_busy  = (state_q == S_BUSY);
  assign arb_grant = grant_q;
  assign arb_abort = arb_abort_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_src_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_src_arbiter
// Description : Directed, table-driven self-checking bench for
//               axis_src_arbiter (NUM_SRC=4, TID_W=2, DATA_W=32, USER_W=2).
//               Source i drives tdata = {i, 16'h0, dat}, tkeep = 4'hF,
//               tstrb = i+1, tuser = i, so the expected output beat follows
//               from the expected source index and data byte alone.
//               Honours AXIS_ARB_TIMEOUT_EN for the starvation scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_src_arbiter;

  localparam int NUM_SRC = 4;
  localparam int TID_W   = 2;
  localparam int DATA_W  = 32;
  localparam int USER_W  = 2;
  localparam int STRB_W  = 4;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic [NUM_SRC-1:0]          s_tvalid = '0;
  logic [NUM_SRC-1:0]          s_tready;
  logic [NUM_SRC*DATA_W-1:0]   s_tdata = '0;
  logic [NUM_SRC*STRB_W-1:0]   s_tstrb = '0;
  logic [NUM_SRC*STRB_W-1:0]   s_tkeep = '0;
  logic [NUM_SRC*USER_W-1:0]   s_tuser = '0;
  logic [NUM_SRC-1:0]          s_tlast = '0;
  logic                        m_tvalid;
  logic [DATA_W-1:0]           m_tdata;
  logic [STRB_W-1:0]           m_tstrb;
  logic [STRB_W-1:0]           m_tkeep;
  logic [USER_W-1:0]           m_tuser;
  logic [TID_W-1:0]            m_tid;
  logic                        m_tlast;
  logic                        m_tready = 1'b0;
  logic                        arb_busy;
  logic [TID_W-1:0]            arb_grant;
  logic                        arb_abort;

  always #5 clk = ~clk;

  axis_src_arbiter #(
    .NUM_SRC     (NUM_SRC),
    .TID_W       (TID_W),
    .DATA_W      (DATA_W),
    .USER_W      (USER_W),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .s_tdata   (s_tdata),
    .s_tstrb   (s_tstrb),
    .s_tkeep   (s_tkeep),
    .s_tuser   (s_tuser),
    .s_tlast   (s_tlast),
    .m_tvalid  (m_tvalid),
    .m_tdata   (m_tdata),
    .m_tstrb   (m_tstrb),
    .m_tkeep   (m_tkeep),
    .m_tuser   (m_tuser),
    .m_tid     (m_tid),
    .m_tlast   (m_tlast),
    .m_tready  (m_tready),
    .arb_busy  (arb_busy),
    .arb_grant (arb_grant),
    .arb_abort (arb_abort)
  );

  // One clock cycle: inputs, expected s_tready before the edge, expected
  // registered outputs after it. rst=1 pulses reset before the step.
  typedef struct {
    logic       rst;
    logic [3:0] vld;
    logic [3:0] lst;
    logic [7:0] dat;
    logic       rdy;
    logic [3:0] e_srdy;
    logic       e_mv;
    logic       e_term;
    logic [7:0] e_dat;
    logic [1:0] e_tid;
    logic       e_ml;
    logic       e_busy;
    logic [1:0] e_grant;
    logic       e_abort;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input logic r, input logic [3:0] vld, input logic [3:0] lst,
                     input logic [7:0] dat, input logic rdy, input logic [3:0] srdy,
                     input logic mv, input logic term, input logic [7:0] edat,
                     input logic [1:0] tid, input logic ml, input logic busy,
                     input logic [1:0] gr, input logic ab);
    vec_t v;
    v.rst = r;     v.vld = vld;    v.lst = lst;     v.dat = dat;   v.rdy = rdy;
    v.e_srdy = srdy; v.e_mv = mv;  v.e_term = term; v.e_dat = edat;
    v.e_tid = tid; v.e_ml = ml;    v.e_busy = busy; v.e_grant = gr; v.e_abort = ab;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=0x%0h want=0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    s_tvalid = v.vld;
    s_tlast  = v.lst;
    m_tready = v.rdy;
    for (int i = 0; i < NUM_SRC; i++) begin
      s_tdata[i*DATA_W +: DATA_W] = {8'(i), 16'h0000, v.dat};
      s_tkeep[i*STRB_W +: STRB_W] = 4'hF;
      s_tstrb[i*STRB_W +: STRB_W] = 4'(i + 1);
      s_tuser[i*USER_W +: USER_W] = 2'(i);
    end
  endtask

  task automatic fill();
    int order[5];
    order = '{0, 1, 2, 0, 1};
    // 3-beat packet from src0, back-to-back beats, busy drops after tlast.
    add(1, 4'b0001, 4'b0000, 8'hA0, 1, 4'b0000, 0, 0, 8'h00, 0, 0, 1, 0, 0);
    add(0, 4'b0001, 4'b0000, 8'hA0, 1, 4'b0001, 1, 0, 8'hA0, 0, 0, 1, 0, 0);
    add(0, 4'b0001, 4'b0000, 8'hA1, 1, 4'b0001, 1, 0, 8'hA1, 0, 0, 1, 0, 0);
    add(0, 4'b0001, 4'b0001, 8'hA2, 1, 4'b0001, 1, 0, 8'hA2, 0, 1, 0, 0, 0);
    add(0, 4'b0000, 4'b0000, 8'h00, 1, 4'b0000, 0, 0, 8'h00, 0, 0, 0, 0, 0);
    // Three continuous requesters, 2-beat packets, one bubble between packets.
    add(1, 4'b0111, 4'b0000, 8'hB0, 1, 4'b0000, 0, 0, 8'h00, 0, 0, 1, 0, 0);
    for (int p = 0; p < 5; p++) begin
      add(0, 4'b0111, 4'b0000, 8'hB0, 1, 4'(1 << order[p]), 1, 0, 8'hB0,
          2'(order[p]), 0, 1, 2'(order[p]), 0);
      add(0, 4'b0111, 4'b0111, 8'hB1, 1, 4'(1 << order[p]), 1, 0, 8'hB1,
          2'(order[p]), 1, 0, 2'(order[p]), 0);
      if (p < 4)
        add(0, 4'b0111, 4'b0000, 8'hB0, 1, 4'b0000, 0, 0, 8'h00, 0, 0, 1,
            2'(order[p+1]), 0);
    end
    add(0, 4'b0000, 4'b0000, 8'h00, 1, 4'b0000, 0, 0, 8'h00, 0, 0, 0, 1, 0);
    // Backpressure: m_tready low for 5 cycles mid-packet from src1.
    add(1, 4'b0010, 4'b0000, 8'hC0, 1, 4'b0000, 0, 0, 8'h00, 0, 0, 1, 1, 0);
    add(0, 4'b0010, 4'b0000, 8'hC0, 1, 4'b0010, 1, 0, 8'hC0, 1, 0, 1, 1, 0);
    for (int k = 0; k < 5; k++)
      add(0, 4'b0010, 4'b0000, 8'hC1, 0, 4'b0000, 1, 0, 8'hC0, 1, 0, 1, 1, 0);
    add(0, 4'b0010, 4'b0000, 8'hC1, 1, 4'b0010, 1, 0, 8'hC1, 1, 0, 1, 1, 0);
    add(0, 4'b0010, 4'b0010, 8'hC2, 1, 4'b0010, 1, 0, 8'hC2, 1, 1, 0, 1, 0);
    add(0, 4'b0000, 4'b0000, 8'h00, 1, 4'b0000, 0, 0, 8'h00, 0, 0, 0, 1, 0);
    // Reset in the middle of a src1 packet; src0 then wins the tie.
    add(1, 4'b0010, 4'b0000, 8'hD0, 1, 4'b0000, 0, 0, 8'h00, 0, 0, 1, 1, 0);
    add(0, 4'b0010, 4'b0000, 8'hD0, 1, 4'b0010, 1, 0, 8'hD0, 1, 0, 1, 1, 0);
    add(1, 4'b0011, 4'b0000, 8'hD1, 1, 4'b0000, 0, 0, 8'h00, 0, 0, 1, 0, 0);
    add(0, 4'b0011, 4'b0000, 8'hD1, 1, 4'b0001, 1, 0, 8'hD1, 0, 0, 1, 0, 0);
    add(0, 4'b0011, 4'b0011, 8'hD2, 1, 4'b0001, 1, 0, 8'hD2, 0, 1, 0, 0, 0);
    add(0, 4'b0010, 4'b0000, 8'hD0, 1, 4'b0000, 0, 0, 8'h00, 0, 0, 1, 1, 0);
    // Single-beat packets from src3 only.
    add(1, 4'b1000, 4'b1000, 8'hF0, 1, 4'b0000, 0, 0, 8'h00, 0, 0, 1, 3, 0);
    for (int k = 0; k < 3; k++) begin
      add(0, 4'b1000, 4'b1000, 8'(8'hF0 + k), 1, 4'b1000, 1, 0, 8'(8'hF0 + k),
          3, 1, 0, 3, 0);
      if (k < 2)
        add(0, 4'b1000, 4'b1000, 8'(8'hF1 + k), 1, 4'b0000, 0, 0, 8'h00,
            0, 0, 1, 3, 0);
    end
    // src2 stalls after its first beat while src3 is waiting.
    add(1, 4'b1100, 4'b0000, 8'hE0, 1, 4'b0000, 0, 0, 8'h00, 0, 0, 1, 2, 0);
    add(0, 4'b1100, 4'b0000, 8'hE0, 1, 4'b0100, 1, 0, 8'hE0, 2, 0, 1, 2, 0);
`ifdef AXIS_ARB_TIMEOUT_EN
    for (int k = 0; k < 16; k++)
      add(0, 4'b1000, 4'b0000, 8'hE1, 1, 4'b0100, 0, 0, 8'h00, 0, 0, 1, 2, 0);
    add(0, 4'b1000, 4'b0000, 8'hE1, 1, 4'b0000, 1, 1, 8'h00, 2, 1, 0, 2, 1);
`else
    for (int k = 0; k < 20; k++)
      add(0, 4'b1000, 4'b0000, 8'hE1, 1, 4'b0100, 0, 0, 8'h00, 0, 0, 1, 2, 0);
    add(0, 4'b1100, 4'b0100, 8'hE1, 1, 4'b0100, 1, 0, 8'hE1, 2, 1, 0, 2, 0);
`endif
    add(0, 4'b1000, 4'b1000, 8'hE5, 1, 4'b0000, 0, 0, 8'h00, 0, 0, 1, 3, 0);
    add(0, 4'b1000, 4'b1000, 8'hE5, 1, 4'b1000, 1, 0, 8'hE5, 3, 1, 0, 3, 0);
  endtask

  initial begin
    vec_t        v;
    logic [31:0] exp_data;
    fill();
    for (int k = 0; k < vecs.size(); k++) begin
      v = vecs[k];
      @(negedge clk);
      if (v.rst) begin
        rst_n = 1'b0;
        drive(v);
        #1;
        chk("rst_m_tvalid",  k, 32'(m_tvalid),  32'h0);
        chk("rst_m_tdata",   k, 32'(m_tdata),   32'h0);
        chk("rst_m_tstrb",   k, 32'(m_tstrb),   32'h0);
        chk("rst_m_tkeep",   k, 32'(m_tkeep),   32'h0);
        chk("rst_m_tuser",   k, 32'(m_tuser),   32'h0);
        chk("rst_m_tid",     k, 32'(m_tid),     32'h0);
        chk("rst_m_tlast",   k, 32'(m_tlast),   32'h0);
        chk("rst_s_tready",  k, 32'(s_tready),  32'h0);
        chk("rst_arb_busy",  k, 32'(arb_busy),  32'h0);
        chk("rst_arb_grant", k, 32'(arb_grant), 32'h0);
        chk("rst_arb_abort", k, 32'(arb_abort), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        drive(v);
      end
      #1;
      chk("s_tready", k, 32'(s_tready), 32'(v.e_srdy));
      @(posedge clk);
      #1;
      chk("m_tvalid",  k, 32'(m_tvalid),  32'(v.e_mv));
      chk("arb_busy",  k, 32'(arb_busy),  32'(v.e_busy));
      chk("arb_grant", k, 32'(arb_grant), 32'(v.e_grant));
      chk("arb_abort", k, 32'(arb_abort), 32'(v.e_abort));
      if (v.e_mv) begin
        exp_data = v.e_term ? 32'h0 : {8'(v.e_tid), 16'h0000, v.e_dat};
        chk("m_tdata", k, m_tdata,         exp_data);
        chk("m_tid",   k, 32'(m_tid),      32'(v.e_tid));
        chk("m_tlast", k, 32'(m_tlast),    32'(v.e_ml));
        chk("m_tkeep", k, 32'(m_tkeep),    v.e_term ? 32'h0 : 32'hF);
        chk("m_tstrb", k, 32'(m_tstrb),    v.e_term ? 32'h0 : 32'(v.e_tid) + 32'd1);
        if (!v.e_term)
          chk("m_tuser", k, 32'(m_tuser),  32'(v.e_tid));
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
